// File: rtl/lcd_hd44780_ctrl_if.sv
// Byte-write handshake between application logic and the HD44780 controller.
// The requester holds in_valid with in_rs/in_data until it sees in_ready at a clock edge.
interface lcd_hd44780_ctrl_if;
  logic       in_valid;
  logic       in_rs;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_rs, output in_data, input in_ready);
  modport slave  (input in_valid, input in_rs, input in_data, output in_ready);
endinterface

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 8-bit controller: power-up wait, 8-step init sequence, then timed
// command/data writes (setup, E pulse, hold, execution wait) from a valid/ready port.
module lcd_hd44780_ctrl #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned POWERUP_US = 20000,
  parameter int unsigned INIT1_US   = 4100,
  parameter int unsigned INIT2_US   = 100,
  parameter int unsigned CMD_US     = 40,
  parameter int unsigned CLEAR_US   = 1640,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned E_CYC      = 25,
  parameter int unsigned HOLD_CYC   = 2,
  parameter bit          TWO_LINE   = 1'b1,
  parameter bit          CURSOR     = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  lcd_hd44780_ctrl_if.slave  host,
  output logic               init_done,
  output logic               lcd_rs,
  output logic               lcd_e,
  output logic [7:0]         lcd_db
);

  localparam int unsigned CYC_US = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;

  // Counter reload values are (N-1): a state lasts N cycles and exits on zero.
  localparam logic [31:0] PWR_LD   = 32'(POWERUP_US * CYC_US - 1);
  localparam logic [31:0] INIT1_LD = 32'(INIT1_US * CYC_US - 1);
  localparam logic [31:0] INIT2_LD = 32'(INIT2_US * CYC_US - 1);
  localparam logic [31:0] CMD_LD   = 32'(CMD_US * CYC_US - 1);
  localparam logic [31:0] CLEAR_LD = 32'(CLEAR_US * CYC_US - 1);
  localparam logic [31:0] SETUP_LD = 32'(SETUP_CYC - 1);
  localparam logic [31:0] E_LD     = 32'(E_CYC - 1);
  localparam logic [31:0] HOLD_LD  = 32'(HOLD_CYC - 1);

  localparam logic [7:0] FUNC_SET = TWO_LINE ? 8'h38 : 8'h30;
  localparam logic [7:0] DISP_ON  = CURSOR ? 8'h0E : 8'h0C;

  typedef enum logic [2:0] {
    PWR_WAIT, INIT_LOAD, SETUP, PULSE, HOLD, EXEC_WAIT, IDLE
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [2:0]  idx;
  logic        ready;

  assign host.in_ready = ready;

  function automatic logic [7:0] init_byte(input logic [2:0] i);
    logic [7:0] b;
    case (i)
      3'd3:    b = FUNC_SET;
      3'd4:    b = 8'h08;
      3'd5:    b = 8'h01;
      3'd6:    b = 8'h06;
      3'd7:    b = DISP_ON;
      default: b = 8'h30;
    endcase
    return b;
  endfunction

  // The first two wake-up bytes need the long datasheet delays; clear/home are slow.
  function automatic logic [31:0] exec_load(input logic init_phase, input logic [2:0] i,
                                            input logic rs, input logic [7:0] db);
    logic [31:0] ld;
    if (init_phase && i == 3'd0)
      ld = INIT1_LD;
    else if (init_phase && i == 3'd1)
      ld = INIT2_LD;
    else if (!rs && (db == 8'h01 || db == 8'h02 || db == 8'h03))
      ld = CLEAR_LD;
    else
      ld = CMD_LD;
    return ld;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PWR_WAIT;
      cnt       <= PWR_LD;
      idx       <= 3'd0;
      init_done <= 1'b0;
      ready     <= 1'b0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_db    <= 8'h00;
    end else begin
      case (state)
        PWR_WAIT: begin
          if (cnt == 32'd0) state <= INIT_LOAD;
          else              cnt   <= cnt - 32'd1;
        end
        INIT_LOAD: begin
          lcd_rs <= 1'b0;
          lcd_db <= init_byte(idx);
          cnt    <= SETUP_LD;
          state  <= SETUP;
        end
        SETUP: begin
          if (cnt == 32'd0) begin
            lcd_e <= 1'b1;
            cnt   <= E_LD;
            state <= PULSE;
          end else cnt <= cnt - 32'd1;
        end
        PULSE: begin
          if (cnt == 32'd0) begin
            lcd_e <= 1'b0;
            cnt   <= HOLD_LD;
            state <= HOLD;
          end else cnt <= cnt - 32'd1;
        end
        HOLD: begin
          if (cnt == 32'd0) begin
            cnt   <= exec_load(!init_done, idx, lcd_rs, lcd_db);
            state <= EXEC_WAIT;
          end else cnt <= cnt - 32'd1;
        end
        EXEC_WAIT: begin
          if (cnt == 32'd0) begin
            if (!init_done && idx != 3'd7) begin
              idx   <= idx + 3'd1;
              state <= INIT_LOAD;
            end else begin
              init_done <= 1'b1;
              ready     <= 1'b1;
              state     <= IDLE;
            end
          end else cnt <= cnt - 32'd1;
        end
        IDLE: begin
          if (host.in_valid) begin
            lcd_rs <= host.in_rs;
            lcd_db <= host.in_data;
            ready  <= 1'b0;
            cnt    <= SETUP_LD;
            state  <= SETUP;
          end
        end
        default: state <= PWR_WAIT;
      endcase
    end
  end

endmodule
